// File: rtl/bram_block_dp_if.sv
// Dual-port BRAM bus: per-port access/read-back signals plus write-write collision status.
// Vectors are MSB-first by value: the leftmost WEN bit enables the most-significant data byte.
interface bram_block_dp_if #(
   parameter int unsigned C_PORT_DWIDTH = 32,
   parameter int unsigned C_PORT_AWIDTH = 32,
   parameter int unsigned C_NUM_WE      = C_PORT_DWIDTH / 8
);
   logic                     BRAM_EN_A;
   logic [C_NUM_WE-1:0]      BRAM_WEN_A;
   logic [C_PORT_AWIDTH-1:0] BRAM_Addr_A;
   logic [C_PORT_DWIDTH-1:0] BRAM_Dout_A;
   logic [C_PORT_DWIDTH-1:0] BRAM_Din_A;
   logic                     BRAM_RdValid_A;

   logic                     BRAM_EN_B;
   logic [C_NUM_WE-1:0]      BRAM_WEN_B;
   logic [C_PORT_AWIDTH-1:0] BRAM_Addr_B;
   logic [C_PORT_DWIDTH-1:0] BRAM_Dout_B;
   logic [C_PORT_DWIDTH-1:0] BRAM_Din_B;
   logic                     BRAM_RdValid_B;

   logic                     BRAM_Collision;
   logic [15:0]              BRAM_Coll_Count;

   modport master (
      output BRAM_EN_A, BRAM_WEN_A, BRAM_Addr_A, BRAM_Dout_A,
      output BRAM_EN_B, BRAM_WEN_B, BRAM_Addr_B, BRAM_Dout_B,
      input  BRAM_Din_A, BRAM_RdValid_A, BRAM_Din_B, BRAM_RdValid_B,
      input  BRAM_Collision, BRAM_Coll_Count
   );

   modport slave (
      input  BRAM_EN_A, BRAM_WEN_A, BRAM_Addr_A, BRAM_Dout_A,
      input  BRAM_EN_B, BRAM_WEN_B, BRAM_Addr_B, BRAM_Dout_B,
      output BRAM_Din_A, BRAM_RdValid_A, BRAM_Din_B, BRAM_RdValid_B,
      output BRAM_Collision, BRAM_Coll_Count
   );
endinterface

// File: rtl/bram_block_dp.sv
// True dual-port, read-first block RAM with byte enables, optional output register and
// write-write collision detection (port A wins overlapping bytes).
module bram_block_dp #(
   parameter int unsigned C_MEMSIZE     = 'h2000,
   parameter int unsigned C_PORT_DWIDTH = 32,
   parameter int unsigned C_PORT_AWIDTH = 32,
   parameter int unsigned C_NUM_WE      = C_PORT_DWIDTH / 8,
   parameter int unsigned C_OUTREG      = 0,
   parameter string       C_FAMILY      = "spartan6"
) (
   input logic            BRAM_Clk,
   input logic            BRAM_Rst,
   bram_block_dp_if.slave bus
);
   localparam int unsigned OffW  = $clog2(C_NUM_WE);
   localparam int unsigned Depth = C_MEMSIZE / C_NUM_WE;
   localparam int unsigned IdxW  = $clog2(Depth);

   typedef logic [C_PORT_DWIDTH-1:0] word_t;

   if (C_PORT_DWIDTH != 32 && C_PORT_DWIDTH != 64) begin : g_bad_dwidth
      $error("bram_block_dp: C_PORT_DWIDTH must be 32 or 64");
   end
   if ((C_MEMSIZE & (C_MEMSIZE - 1)) != 0 || C_MEMSIZE < 'h800 || C_MEMSIZE > 'h40000)
   begin : g_bad_memsize
      $error("bram_block_dp: C_MEMSIZE must be a power of two in 'h800..'h40000");
   end
   if (C_FAMILY == "") begin : g_bad_family
      $error("bram_block_dp: C_FAMILY must name a target family");
   end

   word_t mem_q [Depth];

   logic [IdxW-1:0] idx_a, idx_b;
   logic            wr_a, wr_b;
   logic            coll_d, coll_q;
   logic [15:0]     cnt_d, cnt_q;
   word_t           rd_a_q, rd_b_q;
   logic            vld_a_q, vld_b_q;

   // Byte-offset bits drop out, high bits alias by truncation.
   assign idx_a = IdxW'(bus.BRAM_Addr_A >> OffW);
   assign idx_b = IdxW'(bus.BRAM_Addr_B >> OffW);
   assign wr_a  = bus.BRAM_EN_A && (bus.BRAM_WEN_A != '0);
   assign wr_b  = bus.BRAM_EN_B && (bus.BRAM_WEN_B != '0);

   // Port B is applied first so port A's later assignment wins any shared byte.
   always_ff @(posedge BRAM_Clk) begin
      if (!BRAM_Rst) begin
         for (int unsigned j = 0; j < C_NUM_WE; j++) begin
            if (bus.BRAM_EN_B && bus.BRAM_WEN_B[j]) begin
               mem_q[idx_b][8*j +: 8] <= bus.BRAM_Dout_B[8*j +: 8];
            end
            if (bus.BRAM_EN_A && bus.BRAM_WEN_A[j]) begin
               mem_q[idx_a][8*j +: 8] <= bus.BRAM_Dout_A[8*j +: 8];
            end
         end
      end
   end

   always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
      if (BRAM_Rst) begin
         rd_a_q  <= '0;
         rd_b_q  <= '0;
         vld_a_q <= 1'b0;
         vld_b_q <= 1'b0;
      end else begin
         vld_a_q <= bus.BRAM_EN_A;
         vld_b_q <= bus.BRAM_EN_B;
         if (bus.BRAM_EN_A) begin
            rd_a_q <= mem_q[idx_a];
         end
         if (bus.BRAM_EN_B) begin
            rd_b_q <= mem_q[idx_b];
         end
      end
   end

   always_comb begin
      coll_d = wr_a && wr_b && (idx_a == idx_b);
      cnt_d  = cnt_q;
      if (coll_d && cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
      if (BRAM_Rst) begin
         coll_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         coll_q <= coll_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.BRAM_Collision  = coll_q;
   assign bus.BRAM_Coll_Count = cnt_q;

   if (C_OUTREG != 0) begin : g_outreg
      word_t out_a_q, out_b_q;
      logic  ov_a_q, ov_b_q;

      always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
         if (BRAM_Rst) begin
            out_a_q <= '0;
            out_b_q <= '0;
            ov_a_q  <= 1'b0;
            ov_b_q  <= 1'b0;
         end else begin
            ov_a_q <= vld_a_q;
            ov_b_q <= vld_b_q;
            if (vld_a_q) begin
               out_a_q <= rd_a_q;
            end
            if (vld_b_q) begin
               out_b_q <= rd_b_q;
            end
         end
      end

      assign bus.BRAM_Din_A     = out_a_q;
      assign bus.BRAM_Din_B     = out_b_q;
      assign bus.BRAM_RdValid_A = ov_a_q;
      assign bus.BRAM_RdValid_B = ov_b_q;
   end else begin : g_noreg
      assign bus.BRAM_Din_A     = rd_a_q;
      assign bus.BRAM_Din_B     = rd_b_q;
      assign bus.BRAM_RdValid_A = vld_a_q;
      assign bus.BRAM_RdValid_B = vld_b_q;
   end
endmodule

// File: tb/tb_bram_block_dp.sv
// Scoreboard bench for bram_block_dp: dut0 uses the default pipeline, dut1 adds the output
// register and is used for the mid-read reset case.
module tb_bram_block_dp;
   logic clk  = 1'b0;
   logic rst0 = 1'b1;
   logic rst1 = 1'b1;
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bram_block_dp_if if0 ();
   bram_block_dp_if if1 ();

   bram_block_dp #(.C_OUTREG(0)) dut0 (.BRAM_Clk(clk), .BRAM_Rst(rst0), .bus(if0));
   bram_block_dp #(.C_OUTREG(1)) dut1 (.BRAM_Clk(clk), .BRAM_Rst(rst1), .bus(if1));

   typedef struct {
      logic [31:0] data;
      bit          care;
      int          cyc;
   } exp_t;

   exp_t q_a0[$], q_b0[$], q_c0[$], q_a1[$], q_b1[$], q_c1[$];

   function automatic exp_t mk(logic [31:0] d, bit care, int lat);
      exp_t e;
      e.data = d;
      e.care = care;
      e.cyc  = cyc + lat;
      return e;
   endfunction

   task automatic check_val(string nm, logic [31:0] act, logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %h required %h", nm, act, exp_v);
      end
   endtask

   task automatic check_pop(string nm, logic [31:0] act, bit have, exp_t e);
      checks++;
      if (!have) begin
         failures++;
         $display("FAIL %s: unexpected output %h at cycle %0d", nm, act, cyc);
      end else if (cyc != e.cyc || (e.care && act !== e.data)) begin
         failures++;
         $display("FAIL %s: got %h at cycle %0d required %h at cycle %0d", nm, act, cyc,
                  e.data, e.cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      bit   h;
      e = '{data: '0, care: 1'b0, cyc: 0};
      if (if0.BRAM_RdValid_A) begin
         h = q_a0.size() > 0; if (h) e = q_a0.pop_front();
         check_pop("rd_a0", if0.BRAM_Din_A, h, e);
      end
      if (if0.BRAM_RdValid_B) begin
         h = q_b0.size() > 0; if (h) e = q_b0.pop_front();
         check_pop("rd_b0", if0.BRAM_Din_B, h, e);
      end
      if (if0.BRAM_Collision) begin
         h = q_c0.size() > 0; if (h) e = q_c0.pop_front();
         check_pop("coll0", 32'(if0.BRAM_Coll_Count), h, e);
      end
      if (if1.BRAM_RdValid_A) begin
         h = q_a1.size() > 0; if (h) e = q_a1.pop_front();
         check_pop("rd_a1", if1.BRAM_Din_A, h, e);
      end
      if (if1.BRAM_RdValid_B) begin
         h = q_b1.size() > 0; if (h) e = q_b1.pop_front();
         check_pop("rd_b1", if1.BRAM_Din_B, h, e);
      end
      if (if1.BRAM_Collision) begin
         h = q_c1.size() > 0; if (h) e = q_c1.pop_front();
         check_pop("coll1", 32'(if1.BRAM_Coll_Count), h, e);
      end
   end

   task automatic op(int d, bit pb, logic [3:0] wen, logic [31:0] addr, logic [31:0] data);
      if (d == 0 && !pb) begin
         if0.BRAM_EN_A = 1'b1; if0.BRAM_WEN_A = wen; if0.BRAM_Addr_A = addr;
         if0.BRAM_Dout_A = data;
      end else if (d == 0) begin
         if0.BRAM_EN_B = 1'b1; if0.BRAM_WEN_B = wen; if0.BRAM_Addr_B = addr;
         if0.BRAM_Dout_B = data;
      end else if (!pb) begin
         if1.BRAM_EN_A = 1'b1; if1.BRAM_WEN_A = wen; if1.BRAM_Addr_A = addr;
         if1.BRAM_Dout_A = data;
      end else begin
         if1.BRAM_EN_B = 1'b1; if1.BRAM_WEN_B = wen; if1.BRAM_Addr_B = addr;
         if1.BRAM_Dout_B = data;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if0.BRAM_EN_A = 1'b0; if0.BRAM_WEN_A = '0; if0.BRAM_EN_B = 1'b0; if0.BRAM_WEN_B = '0;
      if1.BRAM_EN_A = 1'b0; if1.BRAM_WEN_A = '0; if1.BRAM_EN_B = 1'b0; if1.BRAM_WEN_B = '0;
   endtask

   initial begin
      if0.BRAM_EN_A = 0; if0.BRAM_WEN_A = '0; if0.BRAM_Addr_A = '0; if0.BRAM_Dout_A = '0;
      if0.BRAM_EN_B = 0; if0.BRAM_WEN_B = '0; if0.BRAM_Addr_B = '0; if0.BRAM_Dout_B = '0;
      if1.BRAM_EN_A = 0; if1.BRAM_WEN_A = '0; if1.BRAM_Addr_A = '0; if1.BRAM_Dout_A = '0;
      if1.BRAM_EN_B = 0; if1.BRAM_WEN_B = '0; if1.BRAM_Addr_B = '0; if1.BRAM_Dout_B = '0;

      repeat (2) @(posedge clk);
      #1;
      check_val("rst_din_a0", if0.BRAM_Din_A, 32'h0);
      check_val("rst_din_b0", if0.BRAM_Din_B, 32'h0);
      check_val("rst_vld_a0", 32'(if0.BRAM_RdValid_A), 32'h0);
      check_val("rst_vld_b0", 32'(if0.BRAM_RdValid_B), 32'h0);
      check_val("rst_coll0", 32'(if0.BRAM_Collision), 32'h0);
      check_val("rst_cnt0", 32'(if0.BRAM_Coll_Count), 32'h0);
      check_val("rst_din_b1", if1.BRAM_Din_B, 32'h0);
      rst0 = 1'b0;
      rst1 = 1'b0;

      // Write then cross-port read, then partial byte write.
      op(0, 0, 4'b1111, 32'h10, 32'hDEADBEEF); q_a0.push_back(mk('0, 0, 1)); tick();
      op(0, 1, 4'b0000, 32'h10, 32'h0); q_b0.push_back(mk(32'hDEADBEEF, 1, 1)); tick();
      op(0, 0, 4'b0100, 32'h10, 32'h00AA0000); q_a0.push_back(mk(32'hDEADBEEF, 1, 1)); tick();
      op(0, 0, 4'b0000, 32'h10, 32'h0); q_a0.push_back(mk(32'hDEAABEEF, 1, 1)); tick();

      // Writes to distinct words in the same cycle do not collide.
      op(0, 0, 4'b1111, 32'h20, 32'h0); q_a0.push_back(mk('0, 0, 1));
      op(0, 1, 4'b1111, 32'h30, 32'h0); q_b0.push_back(mk('0, 0, 1)); tick();

      // Partially overlapping collision: A owns bytes 3,2; B alone writes byte 1.
      op(0, 0, 4'b1100, 32'h20, 32'h11111111); q_a0.push_back(mk(32'h0, 1, 1));
      op(0, 1, 4'b0110, 32'h20, 32'h22222222); q_b0.push_back(mk(32'h0, 1, 1));
      q_c0.push_back(mk(32'd1, 1, 1)); tick();
      op(0, 0, 4'b0000, 32'h20, 32'h0); q_a0.push_back(mk(32'h11112200, 1, 1)); tick();

      // Read-first against a same-cycle write from the other port.
      op(0, 0, 4'b1111, 32'h30, 32'h5A5A5A5A); q_a0.push_back(mk(32'h0, 1, 1));
      op(0, 1, 4'b0000, 32'h30, 32'h0); q_b0.push_back(mk(32'h0, 1, 1)); tick();
      op(0, 1, 4'b0000, 32'h30, 32'h0); q_b0.push_back(mk(32'h5A5A5A5A, 1, 1)); tick();

      // Address aliasing modulo the 8 KiB array.
      op(0, 0, 4'b1111, 32'h2010, 32'h12345678); q_a0.push_back(mk(32'hDEAABEEF, 1, 1)); tick();
      op(0, 1, 4'b0000, 32'h0010, 32'h0); q_b0.push_back(mk(32'h12345678, 1, 1)); tick();

      // Disabled port B with WEN set must not write.
      op(0, 0, 4'b1111, 32'h44, 32'h0); q_a0.push_back(mk('0, 0, 1));
      if0.BRAM_WEN_B = 4'b1111; if0.BRAM_Addr_B = 32'h10; if0.BRAM_Dout_B = 32'hFFFFFFFF;
      tick();

      // Aliased collision with disjoint bytes, then a full-overlap collision.
      op(0, 0, 4'b1000, 32'h44, 32'hAAAAAAAA); q_a0.push_back(mk(32'h0, 1, 1));
      op(0, 1, 4'b0001, 32'h2046, 32'hBBBBBBBB); q_b0.push_back(mk(32'h0, 1, 1));
      q_c0.push_back(mk(32'd2, 1, 1)); tick();
      op(0, 0, 4'b0000, 32'h44, 32'h0); q_a0.push_back(mk(32'hAA0000BB, 1, 1));
      op(0, 1, 4'b0000, 32'h10, 32'h0); q_b0.push_back(mk(32'h12345678, 1, 1)); tick();
      op(0, 0, 4'b1111, 32'h44, 32'h01020304); q_a0.push_back(mk(32'hAA0000BB, 1, 1));
      op(0, 1, 4'b1111, 32'h44, 32'h05060708); q_b0.push_back(mk(32'hAA0000BB, 1, 1));
      q_c0.push_back(mk(32'd3, 1, 1)); tick();
      op(0, 0, 4'b0000, 32'h44, 32'h0); q_a0.push_back(mk(32'h01020304, 1, 1));
      op(0, 1, 4'b0000, 32'h44, 32'h0); q_b0.push_back(mk(32'h01020304, 1, 1)); tick();

      // Back-to-back reads, then read-write on one word (no collision).
      op(0, 0, 4'b0000, 32'h10, 32'h0); q_a0.push_back(mk(32'h12345678, 1, 1)); tick();
      op(0, 0, 4'b0000, 32'h20, 32'h0); q_a0.push_back(mk(32'h11112200, 1, 1)); tick();
      op(0, 0, 4'b0000, 32'h30, 32'h0); q_a0.push_back(mk(32'h5A5A5A5A, 1, 1)); tick();
      op(0, 0, 4'b0000, 32'h20, 32'h0); q_a0.push_back(mk(32'h11112200, 1, 1));
      op(0, 1, 4'b1111, 32'h20, 32'h0); q_b0.push_back(mk(32'h11112200, 1, 1)); tick();
      repeat (3) tick();
      check_val("cnt0_final", 32'(if0.BRAM_Coll_Count), 32'd3);
      check_val("din_a0_hold", if0.BRAM_Din_A, 32'h11112200);

      // Output-registered instance: two-cycle latency, then reset during a read.
      op(1, 0, 4'b1111, 32'h40, 32'hCAFEF00D); q_a1.push_back(mk('0, 0, 2)); tick();
      op(1, 0, 4'b1111, 32'h48, 32'h0); q_a1.push_back(mk('0, 0, 2));
      op(1, 1, 4'b1111, 32'h48, 32'h0); q_b1.push_back(mk('0, 0, 2));
      q_c1.push_back(mk(32'd1, 1, 1)); tick();
      op(1, 1, 4'b0000, 32'h40, 32'h0); q_b1.push_back(mk(32'hCAFEF00D, 1, 2)); tick();
      repeat (2) tick();
      check_val("cnt1_pre", 32'(if1.BRAM_Coll_Count), 32'd1);

      op(1, 1, 4'b0000, 32'h40, 32'h0); tick();
      rst1 = 1'b1;
      #1;
      check_val("rst1_din_b", if1.BRAM_Din_B, 32'h0);
      check_val("rst1_vld_b", 32'(if1.BRAM_RdValid_B), 32'h0);
      check_val("rst1_cnt", 32'(if1.BRAM_Coll_Count), 32'h0);
      op(1, 0, 4'b1111, 32'h40, 32'hFFFFFFFF); tick();
      tick();
      rst1 = 1'b0;
      repeat (3) tick();
      check_val("rst1_din_b_hold", if1.BRAM_Din_B, 32'h0);
      op(1, 1, 4'b0000, 32'h40, 32'h0); q_b1.push_back(mk(32'hCAFEF00D, 1, 2)); tick();
      repeat (3) tick();

      check_val("q_a0_drained", 32'(q_a0.size()), 32'd0);
      check_val("q_b0_drained", 32'(q_b0.size()), 32'd0);
      check_val("q_c0_drained", 32'(q_c0.size()), 32'd0);
      check_val("q_a1_drained", 32'(q_a1.size()), 32'd0);
      check_val("q_b1_drained", 32'(q_b1.size()), 32'd0);
      check_val("q_c1_drained", 32'(q_c1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bram_block_dp.md
BRAM_BLOCK_DP -- requirements
Module: bram_block_dp

Interface
REQ-001 SHALL have parameter C_MEMSIZE, default 'h2000: memory size in bytes; power of two, 'h800..'h40000.
REQ-002 SHALL have parameter C_PORT_DWIDTH, default 32: data width per port; 32 or 64.
REQ-003 SHALL have parameter C_PORT_AWIDTH, default 32: byte-address width.
REQ-004 SHALL have parameter C_NUM_WE, default C_PORT_DWIDTH/8: byte write enables per port.
REQ-005 SHALL have parameter C_OUTREG, default 0: 1 adds an output register stage per port.
REQ-006 SHALL have parameter C_FAMILY, default "spartan6": target family string.
REQ-007 SHALL have port BRAM_Clk  in  1: single clock for both ports; all logic on its rising edge.
REQ-008 SHALL have port BRAM_Rst  in  1: asynchronous, active-high reset.
REQ-009 SHALL have, for each port x in {A,B}, port BRAM_EN_x  in  1: access enable.
REQ-010 SHALL have port BRAM_WEN_x  in  [0:C_NUM_WE-1]: byte write enables; bit i covers data bits [8i:8i+7].
REQ-011 SHALL have port BRAM_Addr_x  in  [0:C_PORT_AWIDTH-1]: byte address, MSB-first.
REQ-012 SHALL have port BRAM_Dout_x  in  [0:C_PORT_DWIDTH-1]: write data into memory.
REQ-013 SHALL have port BRAM_Din_x  out  [0:C_PORT_DWIDTH-1]: read data from memory.
REQ-014 SHALL have port BRAM_RdValid_x  out  1: one-cycle pulse marking valid BRAM_Din_x.
REQ-015 SHALL have port BRAM_Collision  out  1: one-cycle pulse on a write-write collision.
REQ-016 SHALL have port BRAM_Coll_Count  out  [0:15]: saturating collision counter.

Function
REQ-017 SHALL compute word index = (byte address / C_NUM_WE) mod (C_MEMSIZE/C_NUM_WE); upper bits ignored (aliasing) and byte-offset bits ignored.
REQ-018 SHALL perform, per port, a read when EN=1: with WEN all zero as a pure read, with WEN nonzero as write plus read.
REQ-019 SHALL update, on a write, only the bytes whose WEN bit is 1.
REQ-020 SHALL operate read-first: read data is word contents before any same-cycle write from either port.
REQ-021 SHALL present read data with latency 1+C_OUTREG cycles after the EN edge, with RdValid_x asserted in the same cycle as that data.
REQ-022 SHALL hold Din_x at its last value while RdValid_x=0.
REQ-023 SHALL sustain back-to-back accesses on each port every cycle with no stall.
REQ-024 SHALL detect a collision when both EN=1, both WEN nonzero, and word indices are equal.
REQ-025 SHALL, on collision, resolve per byte: port A wins bytes enabled on both ports; each port writes the bytes only it enables.
REQ-026 SHALL pulse BRAM_Collision 1 cycle after a collision and increment BRAM_Coll_Count the same cycle, saturating at 16'hFFFF.
REQ-027 SHALL not flag collisions for read-write or read-read accesses to the same word.
REQ-028 SHALL have an EN=0 port perform no access and produce no RdValid pulse.

Reset
REQ-029 SHALL, while BRAM_Rst=1, force Din_A/B=0, RdValid_A/B=0, BRAM_Collision=0, BRAM_Coll_Count=0, clear all pipeline stages, and block writes.
REQ-030 SHALL drop any in-flight read on reset mid-operation, with no RdValid pulse after deassertion.
REQ-031 SHALL retain memory array contents through reset (array not reset).
REQ-032 SHALL accept access from the first rising edge after BRAM_Rst deasserts.

Verification
REQ-033 SHALL be verified (defaults) by: A writes 'h10 with 32'hDEADBEEF, WEN=1111; B reads 'h10 next cycle -> Din_B=32'hDEADBEEF with RdValid_B pulse 1 cycle later.
REQ-034 SHALL be verified by: A writes 'h10 with 32'h00AA0000, WEN=0100, then reads 'h10 -> 32'hDEAABEEF.
REQ-035 SHALL be verified by: word 'h20=0; same cycle A writes 32'h11111111 WEN=1100 and B writes 32'h22222222 WEN=0110 -> reads 32'h11112200; Collision pulse; Coll_Count=1.
REQ-036 SHALL be verified by: word 'h30=0; same cycle A writes 32'h5A5A5A5A and B reads 'h30 -> Din_B=0, no Collision; next B read -> 32'h5A5A5A5A.
REQ-037 SHALL be verified by: A writes 'h2010 with 32'h12345678; B reads 'h0010 -> 32'h12345678.
REQ-038 SHALL be verified by: C_OUTREG=1; B reads, then BRAM_Rst pulses during cycle 1 of latency -> no RdValid_B, Din_B=0, Coll_Count=0, and earlier-written data is still readable afterwards.
